// File: rtl/mac_issue_ctrl_if.sv
// rtl/mac_issue_ctrl_if.sv - request/response streams and MAC action ports for mac_issue_ctrl
interface mac_issue_ctrl_if #(
   parameter int TAG_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [63:0]       req_m1;
   logic [63:0]       req_m2;
   logic [63:0]       req_addend;
   logic [TAG_W-1:0]  req_tag;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [127:0]      rsp_result;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_cached;

   logic [63:0]       mac_m1;
   logic [63:0]       mac_m2;
   logic [63:0]       mac_addend;
   logic              mac_en_get_values;
   logic              mac_rdy_get_values;
   logic              mac_en_result;
   logic [127:0]      mac_result;
   logic              mac_rdy_result;

   // Requester and MAC side (drives requests, consumes responses, plays the MAC)
   modport master (
      output req_valid, req_m1, req_m2, req_addend, req_tag, rsp_ready,
      output mac_rdy_get_values, mac_result, mac_rdy_result,
      input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_cached,
      input  mac_m1, mac_m2, mac_addend, mac_en_get_values, mac_en_result
   );

   // Controller side
   modport slave (
      input  req_valid, req_m1, req_m2, req_addend, req_tag, rsp_ready,
      input  mac_rdy_get_values, mac_result, mac_rdy_result,
      output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_cached,
      output mac_m1, mac_m2, mac_addend, mac_en_get_values, mac_en_result
   );
endinterface

// File: rtl/mac_issue_ctrl.sv
// rtl/mac_issue_ctrl.sv - single-outstanding MAC issue controller with repeat-operand result cache
module mac_issue_ctrl #(
   parameter int LAT   = 3,
   parameter int TAG_W = 4
) (
   input  logic                CLK,
   input  logic                RST,
   mac_issue_ctrl_if.slave     bus,
   output logic [31:0]         issue_cnt,
   output logic [31:0]         hit_cnt
);
   localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      RESP
   } state_t;

   state_t            state;
   logic [CW-1:0]     wait_cnt;
   logic [TAG_W-1:0]  lat_tag;

   // Copy of the operands the MAC currently holds; the MAC drops a repeat of these
   logic [63:0]       sh_m1;
   logic [63:0]       sh_m2;
   logic [63:0]       sh_a;
   logic [127:0]      cache_res;

   logic              req_fire;
   logic              req_hit;

   // Only accept while idle; reset masks acceptance so nothing is taken in the reset cycle
   assign bus.req_ready = (state == IDLE) && !RST;
   assign req_fire      = bus.req_valid && bus.req_ready;
   assign req_hit       = (bus.req_m1 == sh_m1) && (bus.req_m2 == sh_m2) &&
                          (bus.req_addend == sh_a);

   // Control FSM with registered outputs; mac_m* double as the latched request triple
   always_ff @(posedge CLK) begin
      if (RST) begin
         state                 <= IDLE;
         wait_cnt              <= '0;
         lat_tag               <= '0;
         sh_m1                 <= '0;
         sh_m2                 <= '0;
         sh_a                  <= '0;
         cache_res             <= '0;
         bus.rsp_valid         <= 1'b0;
         bus.rsp_result        <= '0;
         bus.rsp_tag           <= '0;
         bus.rsp_cached        <= 1'b0;
         bus.mac_m1            <= '0;
         bus.mac_m2            <= '0;
         bus.mac_addend        <= '0;
         bus.mac_en_get_values <= 1'b0;
         bus.mac_en_result     <= 1'b0;
         issue_cnt             <= '0;
         hit_cnt               <= '0;
      end else begin
         bus.mac_en_get_values <= 1'b0;
         bus.mac_en_result     <= 1'b0;
         case (state)
            IDLE: begin
               if (req_fire) begin
                  if (req_hit) begin
                     bus.rsp_valid  <= 1'b1;
                     bus.rsp_result <= cache_res;
                     bus.rsp_tag    <= bus.req_tag;
                     bus.rsp_cached <= 1'b1;
                     hit_cnt        <= hit_cnt + 32'd1;
                     state          <= RESP;
                  end else begin
                     bus.mac_m1     <= bus.req_m1;
                     bus.mac_m2     <= bus.req_m2;
                     bus.mac_addend <= bus.req_addend;
                     lat_tag        <= bus.req_tag;
                     state          <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (bus.mac_rdy_get_values) begin
                  bus.mac_en_get_values <= 1'b1;
                  sh_m1                 <= bus.mac_m1;
                  sh_m2                 <= bus.mac_m2;
                  sh_a                  <= bus.mac_addend;
                  issue_cnt             <= issue_cnt + 32'd1;
                  wait_cnt              <= CW'(LAT - 2);
                  state                 <= WAIT;
               end
            end
            WAIT: begin
               // mac_rdy_result may still be high from the previous result here
               if (wait_cnt == '0) begin
                  state <= CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            CAPTURE: begin
               if (bus.mac_rdy_result) begin
                  bus.mac_en_result <= 1'b1;
                  cache_res         <= bus.mac_result;
                  bus.rsp_valid     <= 1'b1;
                  bus.rsp_result    <= bus.mac_result;
                  bus.rsp_tag       <= lat_tag;
                  bus.rsp_cached    <= 1'b0;
                  state             <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb/tb_mac_issue_ctrl.sv - scoreboard bench for mac_issue_ctrl with a behavioural MAC
module tb_mac_issue_ctrl;
   localparam int LAT   = 3;
   localparam int TAG_W = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] issue_cnt;
   logic [31:0] hit_cnt;

   mac_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

   mac_issue_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus.slave),
      .issue_cnt (issue_cnt),
      .hit_cnt   (hit_cnt)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [127:0]     res;
      logic [TAG_W-1:0] tag;
      logic             cached;
      int               acc;
      int               lat;
   } exp_t;

   exp_t sbq[$];

   logic [63:0] exp_m1, exp_m2, exp_a;
   int          gv_cnt = 0;
   int          res_cnt = 0;
   int          gv_cyc = 0;
   int          first_cyc = 0;
   logic        prev_v = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Behavioural MAC: operands, product+sum, then result; ready stays high once set
   logic [127:0] mac_pipe;
   logic         mac_pipe_v;
   always @(posedge CLK) begin
      if (RST) begin
         mac_pipe_v         <= 1'b0;
         mac_pipe           <= '0;
         bus.mac_result     <= '0;
         bus.mac_rdy_result <= 1'b0;
      end else begin
         mac_pipe_v <= bus.mac_en_get_values;
         if (bus.mac_en_get_values)
            mac_pipe <= {64'd0, bus.mac_m1} * {64'd0, bus.mac_m2} + {64'd0, bus.mac_addend};
         if (mac_pipe_v) begin
            bus.mac_result     <= mac_pipe;
            bus.mac_rdy_result <= 1'b1;
         end
      end
   end

   // Monitor: enable pulses and response handshakes checked against the scoreboard
   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.mac_en_get_values) begin
            gv_cnt++;
            gv_cyc = cyc;
            chk("issue_m1", bus.mac_m1, exp_m1);
            chk("issue_m2", bus.mac_m2, exp_m2);
            chk("issue_addend", bus.mac_addend, exp_a);
            chk("en_exclusive", bus.mac_en_result, 1'b0);
         end
         if (bus.mac_en_result) begin
            res_cnt++;
            chk("en_result_delay", cyc - gv_cyc, LAT);
         end
         if (bus.rsp_valid && !prev_v) first_cyc = cyc;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp actual=%0h required=none", bus.rsp_result);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("rsp_result", bus.rsp_result, e.res);
               chk("rsp_tag", bus.rsp_tag, e.tag);
               chk("rsp_cached", bus.rsp_cached, e.cached);
               chk("rsp_latency", first_cyc - e.acc, e.lat);
            end
         end
      end
      prev_v = bus.rsp_valid;
   end

   task automatic chk_reset();
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_result", bus.rsp_result, 128'd0);
      chk("rst_rsp_tag", bus.rsp_tag, 0);
      chk("rst_rsp_cached", bus.rsp_cached, 1'b0);
      chk("rst_en_gv", bus.mac_en_get_values, 1'b0);
      chk("rst_en_res", bus.mac_en_result, 1'b0);
      chk("rst_mac_ops", {bus.mac_m1, bus.mac_m2}, 128'd0);
      chk("rst_mac_addend", bus.mac_addend, 64'd0);
      chk("rst_issue_cnt", issue_cnt, 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
   endtask

   task automatic start(input logic [63:0] m1, input logic [63:0] m2, input logic [63:0] a,
                        input logic [TAG_W-1:0] tag, input logic [127:0] res,
                        input logic cached, input int lat);
      int n = 0;
      exp_t e;
      exp_m1 = m1;
      exp_m2 = m2;
      exp_a  = a;
      bus.req_m1     = m1;
      bus.req_m2     = m2;
      bus.req_addend = a;
      bus.req_tag    = tag;
      bus.req_valid  = 1'b1;
      do begin
         @(negedge CLK);
         n++;
      end while (!bus.req_ready && n < 40);
      if (!bus.req_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout actual=0 required=1");
      end else begin
         e.res = res; e.tag = tag; e.cached = cached; e.acc = cyc; e.lat = lat;
         sbq.push_back(e);
      end
      @(posedge CLK);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input int gv0, input int res0, input int d_gv, input int d_res);
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL rsp_timeout actual=%0d required=0", sbq.size());
         sbq.delete();
      end
      chk("gv_pulses", gv_cnt - gv0, d_gv);
      chk("res_pulses", res_cnt - res0, d_res);
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [63:0] m1, input logic [63:0] m2, input logic [63:0] a,
                       input logic [TAG_W-1:0] tag, input logic [127:0] res, input logic cached);
      int g0 = gv_cnt;
      int r0 = res_cnt;
      start(m1, m2, a, tag, res, cached, cached ? 1 : LAT + 2);
      wait_done(g0, r0, cached ? 0 : 1, cached ? 0 : 1);
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      int g0, r0, n;
      RST = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_m1 = '0; bus.req_m2 = '0; bus.req_addend = '0; bus.req_tag = '0;
      bus.rsp_ready = 1'b1;
      bus.mac_rdy_get_values = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_reset();
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_reset", bus.req_ready, 1'b1);
      @(posedge CLK);
      #1;

      send(64'd0, 64'd0, 64'd0, 4'd3, 128'd0, 1'b1);
      chk("hit_cnt_zero_hit", hit_cnt, 32'd1);
      chk("issue_cnt_zero_hit", issue_cnt, 32'd0);

      send(64'd2, 64'd3, 64'd4, 4'd1, 128'd10, 1'b0);
      chk("issue_cnt_first", issue_cnt, 32'd1);

      send(64'd2, 64'd3, 64'd4, 4'd2, 128'd10, 1'b1);
      chk("hit_cnt_repeat", hit_cnt, 32'd2);

      send(ONES, ONES, ONES, 4'd4, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b0);
      chk("issue_cnt_ones", issue_cnt, 32'd2);

      // Back-pressure: response must hold for ten cycles with no MAC activity
      g0 = gv_cnt;
      r0 = res_cnt;
      bus.rsp_ready = 1'b0;
      start(64'd5, 64'd7, 64'd1, 4'd5, 128'd36, 1'b0, LAT + 2);
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("bp_rsp_seen", bus.rsp_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("bp_valid", bus.rsp_valid, 1'b1);
         chk("bp_result", bus.rsp_result, 128'd36);
         chk("bp_tag", bus.rsp_tag, 4'd5);
         chk("bp_req_ready", bus.req_ready, 1'b0);
         chk("bp_no_en", {bus.mac_en_get_values, bus.mac_en_result}, 2'b00);
      end
      @(posedge CLK);
      #1 bus.rsp_ready = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("bp_ready_after", bus.req_ready, 1'b1);
      wait_done(g0, r0, 1, 1);
      chk("issue_cnt_bp", issue_cnt, 32'd3);

      // Reset while waiting on the MAC pipeline; in-flight response is dropped
      start(64'd9, 64'd9, 64'd9, 4'd6, 128'd90, 1'b0, LAT + 2);
      @(posedge CLK);
      #1 RST = 1'b1;
      sbq.delete();
      @(posedge CLK);
      @(negedge CLK);
      chk_reset();
      @(posedge CLK);
      #1 RST = 1'b0;
      send(64'd2, 64'd3, 64'd4, 4'd7, 128'd10, 1'b0);
      chk("issue_cnt_post_rst", issue_cnt, 32'd1);
      chk("hit_cnt_post_rst", hit_cnt, 32'd0);

      repeat (3) @(posedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
